demux_1to4: RTL and testbench



---
 rtl/demux_1to4_pkg.sv | 28 ++
 rtl/demux_1to4_if.sv | 55 +++++
 rtl/demux_1to4_sat_counter.sv | 26 ++
 rtl/demux_1to4.sv | 76 +++++++
 tb/tb_demux_1to4.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/demux_1to4_pkg.sv
// -----------------------------------------------------------------------------
// demux_1to4_pkg
//   Shared constants and helpers for the registered 1-to-4 demultiplexer.
//   NUM_LANES : number of output lanes
//   SEL_W     : width of the lane select
//   lane_e    : symbolic lane names matching select encodings
//   sel_onehot: decodes a select into a one-hot lane mask
// -----------------------------------------------------------------------------
package demux_1to4_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [SEL_W-1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;

    function automatic logic [NUM_LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_LANES-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_1to4_if.sv
// -----------------------------------------------------------------------------
// demux_1to4_if
//   Bundles the demultiplexer's data/select/enable inputs and its lane,
//   valid and counter outputs.
//   i              : data word to route (WIDTH)
//   selection_line : lane select (SEL_W)
//   en             : routing enable
//   y              : four lanes, lane k at y[k*WIDTH +: WIDTH]
//   y_valid        : one-hot marker of the lane loaded last enabled cycle
//   cnt0..cnt3     : per-lane saturating routing counts (CNT_W)
//   master modport : the source driving i/selection_line/en
//   slave modport  : the demultiplexer itself
// -----------------------------------------------------------------------------
interface demux_1to4_if
    import demux_1to4_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
);

    logic [WIDTH-1:0]           i;
    logic [SEL_W-1:0]           selection_line;
    logic                       en;
    logic [NUM_LANES*WIDTH-1:0] y;
    logic [NUM_LANES-1:0]       y_valid;
    logic [CNT_W-1:0]           cnt0;
    logic [CNT_W-1:0]           cnt1;
    logic [CNT_W-1:0]           cnt2;
    logic [CNT_W-1:0]           cnt3;

    modport master (
        output i,
        output selection_line,
        output en,
        input  y,
        input  y_valid,
        input  cnt0,
        input  cnt1,
        input  cnt2,
        input  cnt3
    );

    modport slave (
        input  i,
        input  selection_line,
        input  en,
        output y,
        output y_valid,
        output cnt0,
        output cnt1,
        output cnt2,
        output cnt3
    );

endinterface

// File: rtl/demux_1to4_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   CNT_W-bit up counter with synchronous clear and saturation at all-ones.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear (priority over inc)
//   inc   : increment request
//   count : current count; holds at 2^CNT_W-1 instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// -----------------------------------------------------------------------------
// demux_1to4
//   Registered 1-to-4 demultiplexer. Each enabled edge loads the selected
//   lane with the input word, zeroes the other lanes, flags the lane in
//   y_valid and bumps that lane's saturating counter. A disabled edge zeroes
//   all lanes and y_valid while counters hold. One cycle latency; all
//   outputs come straight from flops.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears lanes, valid and counters
//   bus : demux_1to4_if slave port (i, selection_line, en -> y, y_valid,
//         cnt0..cnt3)
// -----------------------------------------------------------------------------
module demux_1to4
    import demux_1to4_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    demux_1to4_if.slave  bus
);

    logic [NUM_LANES-1:0]       lane_mask;
    logic [NUM_LANES*WIDTH-1:0] y_next;
    logic [NUM_LANES*WIDTH-1:0] y_q;
    logic [NUM_LANES-1:0]       y_valid_q;
    logic [CNT_W-1:0]           cnt_q [NUM_LANES];

    // Lane mask doubles as the counter increment vector, so a disabled cycle
    // naturally selects nothing.
    always_comb begin
        lane_mask = '0;
        if (bus.en) begin
            lane_mask = sel_onehot(bus.selection_line);
        end
    end

    always_comb begin
        y_next = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (lane_mask[k]) begin
                y_next[k*WIDTH +: WIDTH] = bus.i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= '0;
        end else begin
            y_q       <= y_next;
            y_valid_q <= lane_mask;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (lane_mask[g]),
            .count (cnt_q[g])
        );
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.cnt0    = cnt_q[0];
    assign bus.cnt1    = cnt_q[1];
    assign bus.cnt2    = cnt_q[2];
    assign bus.cnt3    = cnt_q[3];

endmodule

// File: tb/tb_demux_1to4.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4
//   Directed bench for demux_1to4. Instance a: WIDTH=1, CNT_W=8.
//   Instance b: WIDTH=8, CNT_W=3 (saturation and wide-data cases).
// -----------------------------------------------------------------------------
module tb_demux_1to4;

    logic clk;
    logic rst;

    int checks;
    int errors;

    demux_1to4_if #(.WIDTH(1), .CNT_W(8)) bus_a ();
    demux_1to4_if #(.WIDTH(8), .CNT_W(3)) bus_b ();

    demux_1to4 #(.WIDTH(1), .CNT_W(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    demux_1to4 #(.WIDTH(8), .CNT_W(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_all(input string tag, input logic [3:0] ey, input logic [3:0] ev,
                               input logic [7:0] c0, input logic [7:0] c1,
                               input logic [7:0] c2, input logic [7:0] c3);
        check({tag, ".y"},       64'(bus_a.y),       64'(ey));
        check({tag, ".y_valid"}, 64'(bus_a.y_valid), 64'(ev));
        check({tag, ".cnt0"},    64'(bus_a.cnt0),    64'(c0));
        check({tag, ".cnt1"},    64'(bus_a.cnt1),    64'(c1));
        check({tag, ".cnt2"},    64'(bus_a.cnt2),    64'(c2));
        check({tag, ".cnt3"},    64'(bus_a.cnt3),    64'(c3));
    endtask

    // Expected one-hot patterns for the sweep, written out by hand.
    logic [3:0] sweep_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    // Expected cnt0 of the 3-bit counter after each of 10 enabled cycles.
    logic [2:0] sat_exp [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};

    initial begin
        checks = 0;
        errors = 0;

        rst = 1'b1;
        bus_a.i = 1'b1;  bus_a.selection_line = 2'd2; bus_a.en = 1'b1;
        bus_b.i = 8'hFF; bus_b.selection_line = 2'd2; bus_b.en = 1'b1;

        // Reset held two cycles with routing requested.
        for (int n = 0; n < 2; n++) begin
            tick();
            check_a_all("reset_a", 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
            check("reset_b.y", 64'(bus_b.y), 64'h0);
            check("reset_b.cnt2", 64'(bus_b.cnt2), 64'h0);
        end

        rst = 1'b0;
        bus_b.en = 1'b0;

        // Sweep lanes 0..3 back to back.
        bus_a.i = 1'b1;
        bus_a.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus_a.selection_line = 2'(s);
            tick();
            check($sformatf("sweep%0d.y", s), 64'(bus_a.y), 64'(sweep_exp[s]));
            check($sformatf("sweep%0d.y_valid", s), 64'(bus_a.y_valid), 64'(sweep_exp[s]));
        end
        check_a_all("sweep_end", 4'b1000, 4'b1000, 8'd1, 8'd1, 8'd1, 8'd1);
        check("idle_b.y_valid", 64'(bus_b.y_valid), 64'h0);

        // Zero data still flags the lane and counts.
        bus_a.i = 1'b0;
        bus_a.selection_line = 2'd3;
        tick();
        check_a_all("zero", 4'b0000, 4'b1000, 8'd1, 8'd1, 8'd1, 8'd2);

        // Route lane 1, then disable for three cycles.
        bus_a.i = 1'b1;
        bus_a.selection_line = 2'd1;
        tick();
        check_a_all("route1", 4'b0010, 4'b0010, 8'd1, 8'd2, 8'd1, 8'd2);
        bus_a.en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check_a_all($sformatf("dis%0d", n), 4'b0000, 4'b0000, 8'd1, 8'd2, 8'd1, 8'd2);
        end

        // Saturation on the 3-bit counters, wide data on lane 0.
        bus_b.i = 8'hA5;
        bus_b.selection_line = 2'd0;
        bus_b.en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check($sformatf("sat%0d.cnt0", n), 64'(bus_b.cnt0), 64'(sat_exp[n]));
        end
        check("sat.y", 64'(bus_b.y), 64'h0000_00A5);
        check("sat.y_valid", 64'(bus_b.y_valid), 64'h1);
        check("sat.cnt1", 64'(bus_b.cnt1), 64'h0);
        check("sat.cnt2", 64'(bus_b.cnt2), 64'h0);
        check("sat.cnt3", 64'(bus_b.cnt3), 64'h0);

        // Wide data on lane 2.
        bus_b.selection_line = 2'd2;
        tick();
        check("wide.y", 64'(bus_b.y), 64'h00A5_0000);
        check("wide.y_valid", 64'(bus_b.y_valid), 64'h4);
        check("wide.cnt2", 64'(bus_b.cnt2), 64'h1);
        check("wide.cnt0", 64'(bus_b.cnt0), 64'h7);

        // Reset mid-stream wins over en, then routing resumes.
        bus_a.en = 1'b1;
        bus_a.i = 1'b1;
        bus_a.selection_line = 2'd3;
        rst = 1'b1;
        tick();
        check_a_all("mid_rst", 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        check("mid_rst_b.cnt0", 64'(bus_b.cnt0), 64'h0);
        rst = 1'b0;
        bus_a.selection_line = 2'd1;
        tick();
        check_a_all("resume", 4'b0010, 4'b0010, 8'd0, 8'd1, 8'd0, 8'd0);
        check("resume_b.y", 64'(bus_b.y), 64'h00A5_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
